icache_resp: RTL and testbench

Instruction-side responder for the fetch stage: accepts one fetch per cycle (`i_rd`/`i_addr`) and returns `i_data`, `i_miss`, `i_segfault` one cycle later, aligned with the thread at decode. Backed by a direct-mapped line store with one outstanding line fill to instruction memory. A miss never stalls the responder. Fetch replays the missing thread's PC while other threads continue to hit.

---
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_resp_if.sv | 23 ++
 rtl/icache_fill.sv | 107 ++++++++++
 rtl/icache_resp.sv | 125 ++++++++++++
 tb/tb_icache_resp.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and address-field helpers for icache_resp (ICACHE_PREFETCH_EN adds PREFETCH)
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1
`ifdef ICACHE_PREFETCH_EN
    , PREFETCH = 2'd2
`endif
  } fill_state_e;

  // Response word when there is no hit; bit0 clear marks it non-atomic.
  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int num_lines, input int line_words);
    return 32 - 2 - off_w(line_words) - idx_w(num_lines);
  endfunction

endpackage

// File: rtl/icache_resp_if.sv
// rtl/icache_resp_if.sv - fetch and instruction-memory signals of icache_resp
interface icache_resp_if;
  logic        i_rd;
  logic [31:0] i_addr;
  logic        flush;
  logic [31:0] i_data;
  logic        i_miss;
  logic        i_segfault;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  modport master (
    output i_rd, i_addr, flush, mem_rdata, mem_rvalid,
    input  i_data, i_miss, i_segfault, mem_rd, mem_addr
  );

  modport slave (
    input  i_rd, i_addr, flush, mem_rdata, mem_rvalid,
    output i_data, i_miss, i_segfault, mem_rd, mem_addr
  );
endinterface

// File: rtl/icache_fill.sv
// rtl/icache_fill.sv - line fill FSM, word counter and memory handshake (ICACHE_PREFETCH_EN enables next-line prefetch)
module icache_fill
  import icache_pkg::*;
#(
  parameter int   NUM_LINES  = 16,
  parameter int   LINE_WORDS = 4,
  localparam int  OFF_W      = off_w(LINE_WORDS),
  localparam int  IDX_W      = idx_w(NUM_LINES),
  localparam int  LINE_W     = 30 - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              miss_req,
  input  logic [LINE_W-1:0] req_line,
`ifdef ICACHE_PREFETCH_EN
  input  logic              next_ok,
`endif
  input  logic              mem_rvalid,
  output logic              mem_rd,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] line,
  output logic [OFF_W-1:0]  word,
  output logic              data_we,
  output logic              tag_we,
  output logic              inv_we,
  output logic [IDX_W-1:0]  inv_idx
);

  fill_state_e       state_q, state_d;
  logic [OFF_W-1:0]  cnt_q;
  logic [LINE_W-1:0] line_q;
  logic              last_word;
  logic              start;
  logic              word_done;

  assign last_word = (cnt_q == OFF_W'(LINE_WORDS - 1));
  assign start     = (state_q == IDLE) && miss_req && !flush;
  assign word_done = (state_q != IDLE) && mem_rvalid && !flush;

`ifdef ICACHE_PREFETCH_EN
  logic pf_start;
  assign pf_start = word_done && last_word && (state_q == FILL) && next_ok;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = FILL;
      end
      default: begin
        if (flush) begin
          state_d = IDLE;
        end else if (word_done && last_word) begin
`ifdef ICACHE_PREFETCH_EN
          state_d = pf_start ? PREFETCH : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
    endcase
  end

  always_comb begin
    mem_rd  = (state_q != IDLE);
    data_we = word_done;
    tag_we  = word_done && last_word;
    inv_we  = start;
    inv_idx = req_line[IDX_W-1:0];
`ifdef ICACHE_PREFETCH_EN
    // The next line may hold a stale alias; drop it before overwriting words.
    if (pf_start) begin
      inv_we  = 1'b1;
      inv_idx = line_q[IDX_W-1:0] + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      cnt_q  <= '0;
    end else if (start) begin
      line_q <= req_line;
      cnt_q  <= '0;
    end else if (word_done) begin
      cnt_q  <= cnt_q + 1'b1;
`ifdef ICACHE_PREFETCH_EN
      if (pf_start) line_q <= line_q + 1'b1;
`endif
    end
  end

  assign mem_addr = {line_q, cnt_q, 2'b00};
  assign line     = line_q;
  assign word     = cnt_q;

endmodule

// File: rtl/icache_resp.sv
// rtl/icache_resp.sv - direct-mapped instruction responder with one outstanding fill (ICACHE_PREFETCH_EN enables next-line prefetch)
module icache_resp
  import icache_pkg::*;
#(
  parameter int          NUM_LINES  = 16,
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] TEXT_BASE  = 32'h0000_0000,
  parameter logic [31:0] TEXT_LIMIT = 32'h0001_0000
) (
  input logic         clk,
  input logic         rst,
  icache_resp_if.slave bus
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(NUM_LINES);
  localparam int TAG_W  = tag_w(NUM_LINES, LINE_WORDS);
  localparam int LINE_W = IDX_W + TAG_W;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES*LINE_WORDS];

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [32:0]       base_diff, limit_diff;
  logic              segfault, present, miss_req;

  logic              fill_mem_rd;
  logic [31:0]       fill_mem_addr;
  logic [LINE_W-1:0] fill_line;
  logic [OFF_W-1:0]  fill_word;
  logic [IDX_W-1:0]  fill_idx, inv_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              data_we, tag_we, inv_we;

  assign req_off = bus.i_addr[OFF_W+1:2];
  assign req_idx = bus.i_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign req_tag = bus.i_addr[31:OFF_W+IDX_W+2];

  // Borrow bits of 33-bit differences give the unsigned range test.
  assign base_diff  = {1'b0, bus.i_addr} - {1'b0, TEXT_BASE};
  assign limit_diff = {1'b0, bus.i_addr} - {1'b0, TEXT_LIMIT};
  assign segfault   = (|bus.i_addr[1:0]) || base_diff[32] || !limit_diff[32];

  assign fill_idx = fill_line[IDX_W-1:0];
  assign fill_tag = fill_line[LINE_W-1:IDX_W];

  // A line under refill always misses, including on its completing edge.
  assign present  = valid_q[req_idx] && (tag_q[req_idx] == req_tag)
                    && !(fill_mem_rd && (fill_idx == req_idx));
  assign miss_req = bus.i_rd && !segfault && !present;

`ifdef ICACHE_PREFETCH_EN
  logic [LINE_W:0]  next_line;
  logic [IDX_W-1:0] next_idx;
  logic [TAG_W-1:0] next_tag;
  logic [32:0]      next_limit_diff;
  logic             next_ok;

  assign next_line       = {1'b0, fill_line} + 1'b1;
  assign next_idx        = next_line[IDX_W-1:0];
  assign next_tag        = next_line[LINE_W-1:IDX_W];
  assign next_limit_diff = {1'b0, next_line[LINE_W-1:0], {OFF_W{1'b0}}, 2'b00} - {1'b0, TEXT_LIMIT};
  assign next_ok         = !next_line[LINE_W] && next_limit_diff[32]
                           && !(valid_q[next_idx] && (tag_q[next_idx] == next_tag));
`endif

  icache_fill #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_fill (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush),
    .miss_req   (miss_req),
    .req_line   ({req_tag, req_idx}),
`ifdef ICACHE_PREFETCH_EN
    .next_ok    (next_ok),
`endif
    .mem_rvalid (bus.mem_rvalid),
    .mem_rd     (fill_mem_rd),
    .mem_addr   (fill_mem_addr),
    .line       (fill_line),
    .word       (fill_word),
    .data_we    (data_we),
    .tag_we     (tag_we),
    .inv_we     (inv_we),
    .inv_idx    (inv_idx)
  );

  assign bus.mem_rd   = fill_mem_rd;
  assign bus.mem_addr = fill_mem_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.i_data     <= NOP;
      bus.i_miss     <= 1'b0;
      bus.i_segfault <= 1'b0;
    end else begin
      bus.i_data     <= (bus.i_rd && !segfault && present) ? data_q[{req_idx, req_off}] : NOP;
      bus.i_miss     <= miss_req;
      bus.i_segfault <= bus.i_rd && segfault;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid_q <= '0;
    end else begin
      if (inv_we) valid_q[inv_idx]  <= 1'b0;
      if (tag_we) valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_q[fill_idx] <= fill_tag;
  end

  always_ff @(posedge clk) begin
    if (data_we) data_q[{fill_idx, fill_word}] <= bus.mem_rdata;
  end

endmodule

// File: tb/tb_icache_resp.sv
// tb/tb_icache_resp.sv - directed self-checking bench for icache_resp (default build)
module tb_icache_resp;

  logic clk = 1'b0;
  logic rst;
  logic auto_mem;
  logic late_rvalid;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  icache_resp_if bus ();

  icache_resp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory answers every word the cycle after it is requested; data encodes the address.
  always @(posedge clk) begin
    #2;
    bus.mem_rvalid = (auto_mem && bus.mem_rd) || late_rvalid;
    bus.mem_rdata  = 32'hC0DE_0000 | bus.mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a);
    bus.i_rd   = 1'b1;
    bus.i_addr = a;
    tick();
    bus.i_rd   = 1'b0;
  endtask

  task automatic resp(input string tag, input logic [31:0] d, input logic m, input logic s);
    check({tag, ".data"}, bus.i_data, d);
    check({tag, ".miss"}, 32'(bus.i_miss), 32'(m));
    check({tag, ".segf"}, 32'(bus.i_segfault), 32'(s));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst         = 1'b1;
    auto_mem    = 1'b1;
    late_rvalid = 1'b0;
    bus.flush   = 1'b0;
    bus.i_rd    = 1'b1;
    bus.i_addr  = 32'h0000_0002;
    ticks(2);
    resp("reset", 32'h0, 1'b0, 1'b0);
    check("reset.mem_rd", 32'(bus.mem_rd), 32'd0);
    check("reset.mem_addr", bus.mem_addr, 32'h0);
    bus.i_rd = 1'b0;
    rst      = 1'b0;
    tick();

    // cold miss on line 1, then hit
    req(32'h0000_0010);
    resp("cold", 32'h0, 1'b1, 1'b0);
    check("cold.mem_rd", 32'(bus.mem_rd), 32'd1);
    check("cold.addr0", bus.mem_addr, 32'h10);
    tick(); check("cold.addr1", bus.mem_addr, 32'h14);
    check("cold.rd_held", 32'(bus.mem_rd), 32'd1);
    tick(); check("cold.addr2", bus.mem_addr, 32'h18);
    tick(); check("cold.addr3", bus.mem_addr, 32'h1C);
    tick(); check("cold.done", 32'(bus.mem_rd), 32'd0);
    req(32'h0000_0010); resp("hit10", 32'hC0DE_0010, 1'b0, 1'b0);
    req(32'h0000_001C); resp("hit1c", 32'hC0DE_001C, 1'b0, 1'b0);

    // segfaults never start a fill
    req(32'h0001_0000); resp("seg_hi", 32'h0, 1'b0, 1'b1);
    check("seg_hi.mem_rd", 32'(bus.mem_rd), 32'd0);
    req(32'h0000_0002); resp("seg_mis", 32'h0, 1'b0, 1'b1);
    tick(); check("seg.mem_rd", 32'(bus.mem_rd), 32'd0);

    // hit under fill, second miss dropped
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    req(32'h0000_0030); resp("l3_cold", 32'h0, 1'b1, 1'b0);
    ticks(4);
    req(32'h0000_0010); resp("l1_flushed", 32'h0, 1'b1, 1'b0);
    req(32'h0000_0034); resp("hit_under_fill", 32'hC0DE_0034, 1'b0, 1'b0);
    check("huf.mem_rd", 32'(bus.mem_rd), 32'd1);
    req(32'h0000_0050); resp("miss_in_fill", 32'h0, 1'b1, 1'b0);
    check("mif.mem_addr", bus.mem_addr, 32'h18);
    ticks(2);
    check("mif.no_second", 32'(bus.mem_rd), 32'd0);
    req(32'h0000_0014); resp("l1_hit", 32'hC0DE_0014, 1'b0, 1'b0);

    // aliasing on index 0
    req(32'h0000_0000); resp("a0_cold", 32'h0, 1'b1, 1'b0);
    ticks(4);
    req(32'h0000_0000); resp("a0_hit", 32'hC0DE_0000, 1'b0, 1'b0);
    req(32'h0000_0100); resp("a100_miss", 32'h0, 1'b1, 1'b0);
    check("a100.mem_addr", bus.mem_addr, 32'h100);
    ticks(4);
    req(32'h0000_0100); resp("a100_hit", 32'hC0DE_0100, 1'b0, 1'b0);
    req(32'h0000_0000); resp("a0_evicted", 32'h0, 1'b1, 1'b0);
    ticks(4);

    // flush after two words of a fill
    req(32'h0000_0040); resp("f_cold", 32'h0, 1'b1, 1'b0);
    ticks(2);
    check("f.mem_addr2", bus.mem_addr, 32'h48);
    auto_mem   = 1'b0;
    bus.flush  = 1'b1;
    bus.i_rd   = 1'b1;
    bus.i_addr = 32'h0000_0000;
    tick();
    bus.flush = 1'b0;
    bus.i_rd  = 1'b0;
    resp("flush_cycle", 32'hC0DE_0000, 1'b0, 1'b0);
    check("flush.mem_rd", 32'(bus.mem_rd), 32'd0);
    late_rvalid = 1'b1; tick(); late_rvalid = 1'b0;
    check("late.mem_rd", 32'(bus.mem_rd), 32'd0);
    auto_mem = 1'b1;
    req(32'h0000_0000); resp("post_flush", 32'h0, 1'b1, 1'b0);
    ticks(4);
    req(32'h0000_0040); resp("refetch40", 32'h0, 1'b1, 1'b0);
    check("refetch40.addr", bus.mem_addr, 32'h40);
    ticks(4);
    req(32'h0000_0044); resp("hit44", 32'hC0DE_0044, 1'b0, 1'b0);

    // reset in the middle of a fill
    req(32'h0000_0080); resp("r_cold", 32'h0, 1'b1, 1'b0);
    ticks(2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rmid.mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rmid.mem_addr", bus.mem_addr, 32'h0);
    req(32'h0000_0080); resp("r_partial", 32'h0, 1'b1, 1'b0);
    check("r_partial.addr", bus.mem_addr, 32'h80);
    ticks(4);
    req(32'h0000_0084); resp("r_hit", 32'hC0DE_0084, 1'b0, 1'b0);
    req(32'h0000_0044); resp("r_cleared", 32'h0, 1'b1, 1'b0);
    ticks(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
